anton_neopixel_multi: RTL and testbench
=======================================

Name: anton_neopixel_multi

Overview:
Multi-channel WS2812 serializer, the parametrised successor of the single-strip raw driver. It drives CHANNELS strips in lock-step from one shared bit-timing engine. Each channel has its own byte-addressed pixel buffer, written and read over the common 8-bit register bus. Bit timing, strip length, pixel format and loop/one-shot mode are programmable; busy/done status is exposed for the MSS.

Parameters:
CHANNELS, 2, number of strips / neoData outputs (1..8)
PIXELS_MAX, 64, buffer depth per channel in pixels (power of 2)
BIT_TICKS, 8, clk7mhz cycles per data bit (1.14us at 7MHz)
T0H_TICKS, 2, high ticks for a '0' bit (must be < T1H_TICKS)
T1H_TICKS, 5, high ticks for a '1' bit (must be < BIT_TICKS)
RESET_DELAY, 420, low ticks of the latch/reset gap (60us at 7MHz)
BYTE_BITS, CLOG2(PIXELS_MAX)+2, byte address width within one channel buffer (derived)

Ports:
clk7mhz  in  1  single clock; bus and engine both run on it
reset  in  1  asynchronous, active-high
neoData  out  CHANNELS  serial data, one bit per strip
neoState  out  1  1 while in RESET_GAP
pixelsSync  out  1  1-cycle pulse when a frame's reset gap completes
busAddr  in  14  [13]=0 buffer {channel, byte}; [13]=1 registers, [1:0] select
busDataIn  in  8  write data
busWrite  in  1  write strobe, sampled each clk7mhz edge
busRead  in  1  read strobe
busDataOut  out  8  read data, registered

Behaviour:
- Reset: neoData=0, neoState=0, pixelsSync=0, busDataOut=0, all ctrl bits 0, reg_max=0, done=0, FSM=IDLE. Buffer contents are undefined.
- Buffer address: byte = busAddr[BYTE_BITS-1:0], channel = next CLOG2(CHANNELS) bits. An out-of-range channel write is ignored; an out-of-range read returns 0.
- Registers:
  - 0: reg_max[7:0]
  - 1: reg_max[15:8]
  - 2: ctrl {3'b0, 32bit, loop, run, limit, init}
  - 3: status {5'b0, done, in_gap, busy}, read-only
- Read latency is 1 cycle: busDataOut is valid the edge after busRead and holds until the next read.
- Pixel count N = (limit ? min(reg_max+1, PIXELS_MAX) : PIXELS_MAX).
- FSM IDLE -> TRANSMIT: when run=1; the first bit's high phase starts on the 2nd edge after the ctrl write edge.
- FSM TRANSMIT: tick counter 0..BIT_TICKS-1; bit 0..23; pixel 0..N-1.
  - neoData[c] = (tick < (bit ? T1H_TICKS : T0H_TICKS)).
  - Pixel word is latched per channel into a 24-bit shift register at tick 0 of bit 0, and shifted MSB-first in order G,R,B.
  - After the last tick of bit 23 of pixel N-1: go to RESET_GAP.
- Format, 32bit=1: pixel p uses bytes 4p+1 (G), 4p+0 (R), 4p+2 (B); byte 4p+3 is ignored.
- Format, 32bit=0: byte p = [7:6]B [5:3]G [2:0]R, expanded by bit replication to 8 bits each (e.g. R=3'b101 -> 8'b10110110, B=2'b11 -> 8'hFF).
- RESET_GAP: neoData all 0, neoState=1, count RESET_DELAY cycles. Then pixelsSync pulses for 1 cycle, and:
  - if loop=1 and run=1: go to TRANSMIT at pixel 0;
  - otherwise: run is cleared, done is set, go to IDLE.
- Clearing run mid-frame: the current frame and its gap complete; then go to IDLE with done set.
- Setting run while busy has no effect.
- init=1 (self-clearing next cycle): aborts immediately. FSM=IDLE, neoData=0, all ctrl bits and done cleared; the buffer is kept.
- Buffer writes during TRANSMIT are allowed. A pixel's bytes are sampled only at its latch point, so partial updates may tear.
- busy = (FSM != IDLE); in_gap = neoState. done is sticky and is cleared by any write to register 2.
- Same-cycle bus write to ctrl and engine clearing run: the bus write wins.
- Simultaneous busRead and busWrite to the same address: the read returns the old value.

Test Plan:
- Ch0 bytes 4p+0..3 = 0x11, 0x22, 0x33, 0x00; 32bit=1, limit=1, reg_max=0, run=1 -> ch0 sends 24 bits 0x221133 MSB-first. '1' bits are 5 high / 3 low, '0' bits are 2 high / 6 low. Then 420 low cycles, pixelsSync pulses, done=1, run reads 0.
- 8-bit mode, ch1 byte0=0xC5, reg_max=0, limit=1 -> ch1 sends G=0x00, R=0xB6, B=0xFF. Ch0 sends its own byte in lock-step with identical edge timing.
- loop=1, reg_max=2 -> 3 frames of 72 bits, each followed by a 420-cycle gap. Clear run during frame 3 -> frame 3 and its gap complete, then IDLE with done=1.
- Write init=1 mid-pixel -> neoData=0 on the next edge, status reads 0x00, and the ctrl register reads 0x00.
- limit=1, reg_max=1000 with PIXELS_MAX=64 -> exactly 64 pixels (1536 bits) are sent. limit=0 -> also 64 pixels.
- Assert reset during TRANSMIT -> all outputs 0 asynchronously. After release, status=0, and a run=1 write starts a clean frame.

Source files
------------

// File: rtl/anton_neopixel_multi_if.sv
// Register/buffer bus of the multi-strip WS2812 serializer.
// busDataOut is registered and valid one cycle after busRead; no backpressure.
interface anton_neopixel_multi_if;
  logic [13:0] busAddr;
  logic [7:0]  busDataIn;
  logic        busWrite;
  logic        busRead;
  logic [7:0]  busDataOut;

  modport master (output busAddr, busDataIn, busWrite, busRead, input busDataOut);
  modport slave  (input busAddr, busDataIn, busWrite, busRead, output busDataOut);
endinterface

// File: rtl/anton_neopixel_multi.sv
// CHANNELS WS2812 strips serialised in lock-step from one bit-timing engine; first high phase
// 2 edges after run is written, reads return 1 cycle later; the bus never stalls.
module anton_neopixel_multi #(
  parameter int CHANNELS    = 2,
  parameter int PIXELS_MAX  = 64,
  parameter int BIT_TICKS   = 8,
  parameter int T0H_TICKS   = 2,
  parameter int T1H_TICKS   = 5,
  parameter int RESET_DELAY = 420,
  parameter int BYTE_BITS   = $clog2(PIXELS_MAX) + 2
) (
  input  logic                clk7mhz,
  input  logic                reset,
  output logic [CHANNELS-1:0] neoData,
  output logic                neoState,
  output logic                pixelsSync,
  anton_neopixel_multi_if.slave bus
);

  localparam int PIX_W     = BYTE_BITS - 2;
  localparam int BUF_BYTES = 1 << BYTE_BITS;
  localparam int CH_LOG    = $clog2(CHANNELS);
  localparam int CH_W      = (CH_LOG == 0) ? 1 : CH_LOG;
  localparam int TICK_W    = $clog2(BIT_TICKS);
  localparam int GAP_W     = $clog2(RESET_DELAY + 1);

  localparam int C_INIT  = 0;
  localparam int C_LIMIT = 1;
  localparam int C_RUN   = 2;
  localparam int C_LOOP  = 3;
  localparam int C_32    = 4;

  typedef enum logic [1:0] {IDLE, TRANSMIT, RESET_GAP} state_t;

  logic [7:0]           mem [CHANNELS][BUF_BYTES];
  logic [15:0]          reg_max;
  logic [4:0]           ctrl;
  logic                 done;
  state_t               state;
  logic [TICK_W-1:0]    tick;
  logic [4:0]           bitn;
  logic [PIX_W-1:0]     pix;
  logic [PIX_W-1:0]     last_pix;
  logic [GAP_W-1:0]     gap_cnt;
  logic [23:0]          sr       [CHANNELS];
  logic [23:0]          cur_word [CHANNELS];
  logic [7:0]           read_val;
  logic [7:0]           data_out;
  logic                 is_reg;
  logic                 ch_ok;
  logic                 latch_pt;
  logic                 unused_addr;
  logic [CH_W-1:0]      ch_sel;
  logic [BYTE_BITS-1:0] byte_sel;

  assign is_reg         = bus.busAddr[13];
  assign byte_sel       = bus.busAddr[BYTE_BITS-1:0];
  assign ch_sel         = (CH_LOG == 0) ? '0 : CH_W'(bus.busAddr[12:0] >> BYTE_BITS);
  assign ch_ok          = (int'(ch_sel) < CHANNELS);
  assign unused_addr    = ^bus.busAddr;
  assign latch_pt       = (tick == '0) && (bitn == 5'd0);
  assign bus.busDataOut = data_out;

  // 8-bit pixels are BBGGGRRR; each field is widened by repeating its bits.
  function automatic logic [23:0] expand8(input logic [7:0] b);
    return {b[5:3], b[5:3], b[5:4], b[2:0], b[2:0], b[2:1], {4{b[7:6]}}};
  endfunction

  always_comb begin
    last_pix = PIX_W'(PIXELS_MAX - 1);
    if (ctrl[C_LIMIT] && (reg_max < 16'(PIXELS_MAX - 1)))
      last_pix = reg_max[PIX_W-1:0];
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (ctrl[C_32])
        cur_word[c] = {mem[c][{pix, 2'd1}], mem[c][{pix, 2'd0}], mem[c][{pix, 2'd2}]};
      else
        cur_word[c] = expand8(mem[c][BYTE_BITS'(pix)]);
    end
  end

  always_comb begin
    read_val = 8'h00;
    if (is_reg) begin
      case (bus.busAddr[1:0])
        2'd0:    read_val = reg_max[7:0];
        2'd1:    read_val = reg_max[15:8];
        2'd2:    read_val = {3'b000, ctrl};
        default: read_val = {5'b00000, done, neoState, state != IDLE};
      endcase
    end else if (ch_ok) begin
      read_val = mem[ch_sel][byte_sel];
    end
  end

  always_ff @(posedge clk7mhz) begin
    if (bus.busWrite && !is_reg && ch_ok)
      mem[ch_sel][byte_sel] <= bus.busDataIn;
  end

  always_ff @(posedge clk7mhz or posedge reset) begin
    if (reset) begin
      neoData    <= '0;
      neoState   <= 1'b0;
      pixelsSync <= 1'b0;
      data_out   <= 8'h00;
      reg_max    <= 16'h0000;
      ctrl       <= 5'b00000;
      done       <= 1'b0;
      state      <= IDLE;
      tick       <= '0;
      bitn       <= 5'd0;
      pix        <= '0;
      gap_cnt    <= '0;
      for (int c = 0; c < CHANNELS; c++) sr[c] <= 24'h000000;
    end else begin
      pixelsSync <= 1'b0;
      case (state)
        IDLE: begin
          neoData  <= '0;
          neoState <= 1'b0;
          if (ctrl[C_RUN]) begin
            state <= TRANSMIT;
            tick  <= '0;
            bitn  <= 5'd0;
            pix   <= '0;
          end
        end
        TRANSMIT: begin
          // The pixel word is sampled at its first tick, so it feeds bit 23 directly.
          for (int c = 0; c < CHANNELS; c++) begin
            if (latch_pt) begin
              neoData[c] <= int'(tick) < (cur_word[c][23] ? T1H_TICKS : T0H_TICKS);
              sr[c]      <= cur_word[c];
            end else begin
              neoData[c] <= int'(tick) < (sr[c][23] ? T1H_TICKS : T0H_TICKS);
              if (tick == TICK_W'(BIT_TICKS - 1))
                sr[c] <= sr[c] << 1;
            end
          end
          if (tick == TICK_W'(BIT_TICKS - 1)) begin
            tick <= '0;
            if (bitn == 5'd23) begin
              bitn <= 5'd0;
              if (pix >= last_pix) begin
                state   <= RESET_GAP;
                gap_cnt <= '0;
              end else begin
                pix <= pix + 1'b1;
              end
            end else begin
              bitn <= bitn + 5'd1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        RESET_GAP: begin
          neoData <= '0;
          if (gap_cnt == GAP_W'(RESET_DELAY)) begin
            neoState   <= 1'b0;
            pixelsSync <= 1'b1;
            if (ctrl[C_LOOP] && ctrl[C_RUN]) begin
              state <= TRANSMIT;
              tick  <= '0;
              bitn  <= 5'd0;
              pix   <= '0;
            end else begin
              ctrl[C_RUN] <= 1'b0;
              done        <= 1'b1;
              state       <= IDLE;
            end
          end else begin
            neoState <= 1'b1;
            gap_cnt  <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (bus.busRead)
        data_out <= read_val;

      // Bus writes come last so they override any engine update of ctrl/done.
      if (bus.busWrite && is_reg) begin
        case (bus.busAddr[1:0])
          2'd0: reg_max[7:0]  <= bus.busDataIn;
          2'd1: reg_max[15:8] <= bus.busDataIn;
          2'd2: begin
            done <= 1'b0;
            if (bus.busDataIn[C_INIT]) begin
              ctrl       <= 5'b00000;
              state      <= IDLE;
              neoData    <= '0;
              neoState   <= 1'b0;
              pixelsSync <= 1'b0;
            end else begin
              ctrl <= bus.busDataIn[4:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anton_neopixel_multi.sv
// Randomised bench: a waveform monitor decodes every strip and checks it against frames queued
// from a reference model of the buffer image.
module tb_anton_neopixel_multi;
  localparam int CH = 2;
  localparam int PM = 64;
  localparam int BT = 8;
  localparam int T0 = 2;
  localparam int T1 = 5;
  localparam int RD = 420;
  localparam logic [13:0] REG = 14'h2000;

  logic          clk7mhz = 1'b0;
  logic          reset   = 1'b1;
  logic [CH-1:0] neoData;
  logic          neoState;
  logic          pixelsSync;

  anton_neopixel_multi_if bus_if ();

  anton_neopixel_multi #(
    .CHANNELS(CH), .PIXELS_MAX(PM), .BIT_TICKS(BT),
    .T0H_TICKS(T0), .T1H_TICKS(T1), .RESET_DELAY(RD)
  ) dut (
    .clk7mhz(clk7mhz), .reset(reset), .neoData(neoData),
    .neoState(neoState), .pixelsSync(pixelsSync), .bus(bus_if.slave)
  );

  always #5 clk7mhz = ~clk7mhz;

  int   total = 0;
  int   bad   = 0;
  logic [7:0] img [CH][256];
  bit   exp0[$];
  bit   exp1[$];
  int   frame_q[$];
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Widen a w-bit colour field to 8 bits by cycling through its bits MSB first.
  function automatic logic [7:0] widen(input logic [7:0] v, input int w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[w-1-(i%w)];
    return r;
  endfunction

  function automatic logic [23:0] ref_word(input int c, input int p, input bit m32);
    logic [7:0] b;
    if (m32) return {img[c][4*p+1], img[c][4*p], img[c][4*p+2]};
    b = img[c][p];
    return {widen((b >> 3) & 8'h07, 3), widen(b & 8'h07, 3), widen(b >> 6, 2)};
  endfunction

  task automatic push_frame(input bit m32, input bit lim, input int rmax);
    int n;
    logic [23:0] w0, w1;
    n = lim ? ((rmax + 1 < PM) ? rmax + 1 : PM) : PM;
    for (int p = 0; p < n; p++) begin
      w0 = ref_word(0, p, m32);
      w1 = ref_word(1, p, m32);
      for (int b = 23; b >= 0; b--) begin
        exp0.push_back(w0[b]);
        exp1.push_back(w1[b]);
      end
    end
    frame_q.push_back(n * 24);
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk7mhz);
    bus_if.busAddr = a; bus_if.busDataIn = d; bus_if.busWrite = 1'b1;
    @(negedge clk7mhz);
    bus_if.busWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [7:0] d);
    @(negedge clk7mhz);
    bus_if.busAddr = a; bus_if.busRead = 1'b1;
    @(negedge clk7mhz);
    bus_if.busRead = 1'b0;
    d = bus_if.busDataOut;
  endtask

  task automatic wbuf(input int c, input int b, input logic [7:0] d);
    bus_write(14'(c * 256 + b), d);
    img[c][b] = d;
  endtask

  task automatic read_check(input string name, input logic [13:0] a, input logic [7:0] want);
    logic [7:0] d;
    bus_read(a, d);
    check(name, d, want);
  endtask

  task automatic wait_done(input int budget);
    logic [7:0] s;
    int n = 0;
    do begin
      bus_read(REG | 14'd3, s);
      n += 2;
    end while (!s[2] && n < budget);
    check("done_seen", s[2], 1);
    repeat (4) @(negedge clk7mhz);
    check("bits_left", exp0.size() + exp1.size(), 0);
    check("frames_left", frame_q.size(), 0);
  endtask

  // Waveform monitor: decode pulse widths into bits and frames.
  logic [CH-1:0] prev = '0;
  logic [CH-1:0] rise_v;
  int  hi [CH];
  int  bits_seen = 0, gap_seen = 0, cyc = 0, last_rise = 0;
  bit  first = 1'b1;
  bit  e;
  int  want;

  always @(negedge clk7mhz) begin
    cyc++;
    if (!mon_en || reset) begin
      for (int c = 0; c < CH; c++) hi[c] = 0;
      bits_seen = 0; gap_seen = 0; first = 1'b1;
    end else begin
      rise_v = neoData & ~prev;
      if (rise_v != '0) begin
        check("lockstep", rise_v, {CH{1'b1}});
        if (!first) check("bit_period", cyc - last_rise, BT);
        first = 1'b0;
        last_rise = cyc;
      end
      for (int c = 0; c < CH; c++) begin
        if (neoData[c]) begin
          hi[c]++;
        end else if (prev[c]) begin
          want = 0;
          if (c == 0 && exp0.size() > 0) begin e = exp0.pop_front(); want = e ? T1 : T0; end
          if (c == 1 && exp1.size() > 0) begin e = exp1.pop_front(); want = e ? T1 : T0; end
          check($sformatf("ch%0d_high_ticks", c), hi[c], want);
          if (c == 0) bits_seen++;
          hi[c] = 0;
        end
      end
      if (neoState) begin
        gap_seen++;
        check("gap_quiet", neoData, 0);
      end
      if (pixelsSync) begin
        check("gap_len", gap_seen, RD);
        want = (frame_q.size() > 0) ? frame_q.pop_front() : -1;
        check("frame_bits", bits_seen, want);
        bits_seen = 0; gap_seen = 0; first = 1'b1;
      end
    end
    prev = neoData;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n, ps, c, b;
    logic [7:0] d, old;
    bus_if.busAddr = '0; bus_if.busDataIn = '0;
    bus_if.busWrite = 1'b0; bus_if.busRead = 1'b0;

    repeat (3) @(negedge clk7mhz);
    check("rst_data", neoData, 0);
    check("rst_state", neoState, 0);
    check("rst_sync", pixelsSync, 0);
    check("rst_dout", bus_if.busDataOut, 0);
    reset = 1'b0;
    read_check("rst_status", REG | 14'd3, 8'h00);
    read_check("rst_ctrl", REG | 14'd2, 8'h00);
    read_check("rst_max_lo", REG | 14'd0, 8'h00);
    read_check("rst_max_hi", REG | 14'd1, 8'h00);

    for (int ch = 0; ch < CH; ch++)
      for (int by = 0; by < 256; by++) wbuf(ch, by, 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      c = $urandom_range(0, CH - 1);
      b = $urandom_range(0, 255);
      read_check("buf_readback", 14'(c * 256 + b), img[c][b]);
    end

    // Read and write to the same byte in one cycle: the read sees the old byte.
    old = img[1][7];
    @(negedge clk7mhz);
    bus_if.busAddr = 14'(256 + 7); bus_if.busDataIn = ~old;
    bus_if.busWrite = 1'b1; bus_if.busRead = 1'b1;
    @(negedge clk7mhz);
    bus_if.busWrite = 1'b0; bus_if.busRead = 1'b0;
    check("rw_old", bus_if.busDataOut, old);
    img[1][7] = ~old;
    read_check("rw_new", 14'(256 + 7), ~old);

    mon_en = 1'b1;

    // One 32-bit pixel, with start latency.
    wbuf(0, 0, 8'h11); wbuf(0, 1, 8'h22); wbuf(0, 2, 8'h33); wbuf(0, 3, 8'h00);
    bus_write(REG | 14'd0, 8'h00);
    bus_write(REG | 14'd1, 8'h00);
    push_frame(1'b1, 1'b1, 0);
    bus_write(REG | 14'd2, 8'h16);
    @(negedge clk7mhz);
    check("start_edge1", neoData, 0);
    @(negedge clk7mhz);
    check("start_edge2", neoData, {CH{1'b1}});
    wait_done(30000);
    read_check("oneshot_ctrl", REG | 14'd2, 8'h12);
    read_check("oneshot_status", REG | 14'd3, 8'h04);

    // 8-bit format.
    wbuf(1, 0, 8'hC5);
    push_frame(1'b0, 1'b1, 0);
    bus_write(REG | 14'd2, 8'h06);
    wait_done(30000);

    // Loop of 3-pixel frames, run cleared during the third.
    bus_write(REG | 14'd0, 8'h02);
    repeat (3) push_frame(1'b1, 1'b1, 2);
    bus_write(REG | 14'd2, 8'h1E);
    ps = 0; n = 0;
    while (ps < 2 && n < 6000) begin
      @(negedge clk7mhz);
      n++;
      if (pixelsSync) ps++;
    end
    check("loop_syncs", ps, 2);
    repeat (100) @(negedge clk7mhz);
    bus_write(REG | 14'd2, 8'h1A);
    wait_done(30000);
    read_check("loop_ctrl", REG | 14'd2, 8'h1A);

    // init aborts mid-pixel.
    mon_en = 1'b0;
    bus_write(REG | 14'd0, 8'h05);
    bus_write(REG | 14'd2, 8'h16);
    repeat (37) @(negedge clk7mhz);
    bus_write(REG | 14'd2, 8'h01);
    check("init_data", neoData, 0);
    check("init_state", neoState, 0);
    read_check("init_status", REG | 14'd3, 8'h00);
    read_check("init_ctrl", REG | 14'd2, 8'h00);
    mon_en = 1'b1;

    // Limit beyond buffer depth, then no limit.
    bus_write(REG | 14'd0, 8'hE8);
    bus_write(REG | 14'd1, 8'h03);
    push_frame(1'b1, 1'b1, 1000);
    bus_write(REG | 14'd2, 8'h16);
    wait_done(30000);
    push_frame(1'b0, 1'b0, 0);
    bus_write(REG | 14'd2, 8'h04);
    wait_done(30000);

    // Asynchronous reset during a frame.
    read_check("max_hi", REG | 14'd1, 8'h03);
    mon_en = 1'b0;
    bus_write(REG | 14'd2, 8'h16);
    n = 0;
    while (!neoData[0] && n < 100) begin
      @(negedge clk7mhz);
      n++;
    end
    check("pre_reset_high", neoData[0], 1);
    @(posedge clk7mhz);
    #2 reset = 1'b1;
    #1;
    check("arst_data", neoData, 0);
    check("arst_state", neoState, 0);
    check("arst_sync", pixelsSync, 0);
    check("arst_dout", bus_if.busDataOut, 0);
    @(negedge clk7mhz);
    reset = 1'b0;
    read_check("post_rst_status", REG | 14'd3, 8'h00);
    read_check("post_rst_ctrl", REG | 14'd2, 8'h00);
    mon_en = 1'b1;
    push_frame(1'b1, 1'b1, 0);
    bus_write(REG | 14'd2, 8'h16);
    wait_done(30000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
